// File: rtl/word_byte_serializer_pkg.sv
// word_byte_serializer_pkg: state encoding, datapath widths and the byte-select helper
// shared by the word-to-byte serializer.
package word_byte_serializer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // 2'd3 is never produced and falls back to IDLE in the FSM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input logic hi);
        return hi ? w[WORD_W-1:BYTE_W] : w[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: takes one 16-bit word per handshake and emits its two bytes
// back-to-back on an 8-bit valid/ready stream, counting completed words.
module word_byte_serializer
    import word_byte_serializer_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt
);

    state_e            state_q;
    logic [WORD_W-1:0] word_q;
    logic [BYTE_W-1:0] byte_q;
    logic              last_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done;
    logic              load;

    // in_ready is the only combinational path: a word may enter on the same edge the second byte leaves
    assign done     = (state_q == SECOND) && out_ready;
    assign in_ready = (state_q == IDLE) || done;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (done)
                cnt_q <= cnt_q + CNT_W'(1);
            if (load) begin
                state_q <= FIRST;
                word_q  <= in_word;
                byte_q  <= pick_byte(in_word, !LOW_FIRST);
                last_q  <= 1'b0;
                valid_q <= 1'b1;
            end else if (state_q == FIRST && out_ready) begin
                state_q <= SECOND;
                byte_q  <= pick_byte(word_q, LOW_FIRST);
                last_q  <= 1'b1;
            end else if (done || !(state_q inside {IDLE, FIRST, SECOND})) begin
                state_q <= IDLE;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_byte  = byte_q;
    assign out_last  = last_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed plus random stimulus on a low-first and a high-first
// instance sharing inputs; a negedge scoreboard checks every emitted byte.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        out_ready = 1'b0;

    logic        ir1, ov1, ol1, ir0, ov0, ol0;
    logic [7:0]  ob1, ob0, wc1, wc0;

    int checks = 0;
    int passes = 0;
    int exp_cnt = 0;
    logic [8:0] q1[$];
    logic [8:0] q0[$];

    always #5 clk = ~clk;

    word_byte_serializer #(.LOW_FIRST(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_word(in_word),
        .out_valid(ov1), .out_ready(out_ready), .out_byte(ob1), .out_last(ol1), .word_cnt(wc1)
    );

    word_byte_serializer #(.LOW_FIRST(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_word(in_word),
        .out_valid(ov0), .out_ready(out_ready), .out_byte(ob0), .out_last(ol0), .word_cnt(wc0)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words are pushed as they are accepted, bytes popped as they are taken.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            q1.delete();
            q0.delete();
            exp_cnt = 0;
        end else begin
            if (ov1 && out_ready) begin
                chk("sb1 nonempty", 16'(q1.size() > 0), 16'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("sb1 byte", {7'd0, ol1, ob1}, {7'd0, e});
                    if (e[8]) exp_cnt = exp_cnt + 1;
                end
            end
            if (ov0 && out_ready) begin
                chk("sb0 nonempty", 16'(q0.size() > 0), 16'd1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("sb0 byte", {7'd0, ol0, ob0}, {7'd0, e});
                end
            end
            if (in_valid && ir1) begin
                q1.push_back({1'b0, in_word[7:0]});
                q1.push_back({1'b1, in_word[15:8]});
                q0.push_back({1'b0, in_word[15:8]});
                q0.push_back({1'b1, in_word[7:0]});
            end
        end
    end

    initial begin
        logic acc;
        // reset state
        tick();
        tick();
        chk("rst out_valid", 16'(ov1), 16'd0);
        chk("rst out_byte", 16'(ob1), 16'd0);
        chk("rst out_last", 16'(ol1), 16'd0);
        chk("rst word_cnt", 16'(wc1), 16'd0);
        chk("rst in_ready", 16'(ir1), 16'd1);
        rst_n = 1'b1;

        // single word A55A
        in_valid = 1'b1; in_word = 16'hA55A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        chk("a55a b0 valid", 16'(ov1), 16'd1);
        chk("a55a b0 lo", 16'({ol1, ob1}), 16'h05A);
        chk("a55a b0 hi", 16'({ol0, ob0}), 16'h0A5);
        tick();
        chk("a55a b1 lo", 16'({ol1, ob1}), 16'h1A5);
        chk("a55a b1 hi", 16'({ol0, ob0}), 16'h15A);
        chk("a55a b1 in_ready", 16'(ir1), 16'd1);
        tick();
        chk("a55a idle valid", 16'(ov1), 16'd0);
        chk("a55a word_cnt", 16'(wc1), 16'd1);

        // high-first order on 1234
        in_valid = 1'b1; in_word = 16'h1234;
        tick();
        in_valid = 1'b0; #1;
        chk("1234 b0 hi", 16'({ol0, ob0}), 16'h012);
        tick();
        chk("1234 b1 hi", 16'({ol0, ob0}), 16'h134);
        tick();

        // back-to-back 0102, 0304
        in_valid = 1'b1; in_word = 16'h0102;
        tick();
        in_word = 16'h0304; #1;
        chk("b2b 02", 16'({ov1, ob1}), 16'h102);
        chk("b2b ir first", 16'(ir1), 16'd0);
        tick();
        chk("b2b 01", 16'({ov1, ob1}), 16'h101);
        chk("b2b ir second", 16'(ir1), 16'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("b2b 04 no gap", 16'({ov1, ob1}), 16'h104);
        chk("b2b ir first2", 16'(ir1), 16'd0);
        tick();
        chk("b2b 03", 16'({ov1, ob1}), 16'h103);
        tick();
        chk("b2b word_cnt", 16'(wc1), 16'd4);

        // backpressure on BEEF with in_word disturbed mid-stall
        in_valid = 1'b1; in_word = 16'hBEEF;
        tick();
        out_ready = 1'b0; in_word = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall byte", 16'({ov1, ol1, ob1}), 16'h2EF);
            chk("stall in_ready", 16'(ir1), 16'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("stall release", 16'({ol1, ob1}), 16'h1BE);
        tick();
        chk("stall word_cnt", 16'(wc1), 16'd5);

        // reset while in SECOND of CAFE
        in_valid = 1'b1; in_word = 16'hCAFE;
        tick();
        in_valid = 1'b0;
        tick();
        chk("cafe in second", 16'({ol1, ob1}), 16'h1CA);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        chk("midrst valid", 16'(ov1), 16'd0);
        chk("midrst word_cnt", 16'(wc1), 16'd0);
        chk("midrst in_ready", 16'(ir1), 16'd1);
        in_valid = 1'b1; in_word = 16'h1357;
        tick();
        in_valid = 1'b0; #1;
        chk("post rst b0", 16'({ol1, ob1}), 16'h057);
        tick();
        chk("post rst b1", 16'({ol1, ob1}), 16'h113);
        tick();
        chk("post rst word_cnt", 16'(wc1), 16'd1);

        // counter wrap: 255 more words back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_word = 16'($urandom);
            tick();
            tick();
        end
        in_valid = 1'b0;
        chk("wrap pre", 16'(wc1), 16'd255);
        tick();
        chk("wrap zero", 16'(wc1), 16'd0);
        chk("wrap zero hf", 16'(wc0), 16'd0);

        // random traffic, upstream holds in_word until accepted
        for (int i = 0; i < 200; i++) begin
            if (!in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word = 16'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && ir1;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("drain valid", 16'(ov1), 16'd0);
        chk("drain sb1", 16'(q1.size()), 16'd0);
        chk("drain sb0", 16'(q0.size()), 16'd0);
        chk("rand word_cnt", 16'(wc1), 16'(exp_cnt[7:0]));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
